rgb_pwm_driver: RTL and testbench

Output stage placed directly after the 2-bit magnitude comparator that produces the R/G/B indication bits. Drives the three board LED pins with a PWM dimming signal and a soft-start brightness ramp. Colour bits and brightness are latched only at PWM period boundaries, so LEDs never glitch mid-period.

---
 rtl/led_pkg.sv | 9 +
 rtl/tick_gen.sv | 34 +++
 rtl/rgb_pwm_driver.sv | 128 ++++++++++++
 tb/tb_rgb_pwm_driver.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and default parameters for the board LED output stage.
package led_pkg;

  typedef enum logic [1:0] {IDLE, RAMP, RUN} pwm_state_t;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_PRESCALE = 4;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: asserts tick on the last clock of every PRESCALE-cycle window.
module tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0]  LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // With PRESCALE=1 the count never leaves 0, so every cycle is a tick.
  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel LED PWM stage with soft-start ramp; colour and brightness
// are only updated at PWM period boundaries so LEDs never glitch mid-period.
module rgb_pwm_driver
  import led_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r_in,
  input  logic             g_in,
  input  logic             b_in,
  input  logic             en,
  input  logic [CNT_W-1:0] duty,
  input  logic             duty_we,
  output logic             led_r,
  output logic             led_g,
  output logic             led_b,
  output logic             period_tick,
  output logic             ramping
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pwm_state_t       state_q, state_d;
  logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [CNT_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] duty_pend_q, duty_pend_d;
  logic [2:0]       shadow_q, shadow_d;
  logic [2:0]       led_q, led_d;
  logic             period_tick_q, period_tick_d;

  logic             tick, tick_clr, active, boundary;
  logic [CNT_W:0]   level_inc;

  assign active    = (state_q != IDLE);
  assign tick_clr  = !active || !en;
  assign boundary  = active && tick && (pwm_cnt_q == CNT_MAX);
  // One bit wider so a ramp towards the maximum duty cannot wrap to 0.
  assign level_inc = {1'b0, level_q} + (CNT_W + 1)'(1);

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  // NOTE: every variable gets a default before the case so no path can leave
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    pwm_cnt_d     = pwm_cnt_q;
    level_d       = level_q;
    shadow_d      = shadow_q;
    duty_pend_d   = duty_we ? duty : duty_pend_q;
    period_tick_d = boundary && en;
    led_d         = (active && en && (pwm_cnt_q < level_q)) ? shadow_q : 3'b000;

    unique case (state_q)
      IDLE: begin
        pwm_cnt_d = '0;
        level_d   = '0;
        if (en) begin
          state_d  = RAMP;
          shadow_d = {r_in, g_in, b_in};
        end
      end
      RAMP, RUN: begin
        if (!en) begin
          state_d   = IDLE;
          pwm_cnt_d = '0;
          level_d   = '0;
        end else begin
          if (tick) begin
            pwm_cnt_d = pwm_cnt_q + CNT_W'(1);
          end
          if (boundary) begin
            shadow_d = {r_in, g_in, b_in};
            if (state_q == RUN) begin
              level_d = duty_pend_q;
            end else if (level_inc >= {1'b0, duty_pend_q}) begin
              level_d = duty_pend_q;
              state_d = RUN;
            end else begin
              level_d = level_inc[CNT_W-1:0];
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values,
  // independent of the order of statements in this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pwm_cnt_q     <= '0;
      level_q       <= '0;
      duty_pend_q   <= '0;
      shadow_q      <= '0;
      led_q         <= '0;
      period_tick_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pwm_cnt_q     <= pwm_cnt_d;
      level_q       <= level_d;
      duty_pend_q   <= duty_pend_d;
      shadow_q      <= shadow_d;
      led_q         <= led_d;
      period_tick_q <= period_tick_d;
    end
  end

  assign led_r       = led_q[2];
  assign led_g       = led_q[1];
  assign led_b       = led_q[0];
  assign period_tick = period_tick_q;
  assign ramping     = (state_q == RAMP);

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Self-checking bench for rgb_pwm_driver: per-period vector table, directed
// corner sequences and a randomized run against a cycle-count reference model.
module tb_rgb_pwm_driver;

  localparam int CW  = 4;
  localparam int PS  = 1;
  localparam int PER = 1 << CW;

  logic          clk = 1'b0;
  logic          rst, r_in, g_in, b_in, en, duty_we;
  logic [CW-1:0] duty;
  logic          led_r, led_g, led_b, period_tick, ramping;

  int errors = 0;
  int checks = 0;

  rgb_pwm_driver #(.CNT_W(CW), .PRESCALE(PS)) dut (
    .clk         (clk),
    .rst         (rst),
    .r_in        (r_in),
    .g_in        (g_in),
    .b_in        (b_in),
    .en          (en),
    .duty        (duty),
    .duty_we     (duty_we),
    .led_r       (led_r),
    .led_g       (led_g),
    .led_b       (led_b),
    .period_tick (period_tick),
    .ramping     (ramping)
  );

  always #5 clk = ~clk;

  // Reference model: time since ramp start, integer brightness, colour latch.
  bit         m_active, m_ramp, m_pt;
  int         m_cyc, m_level, m_pend;
  logic [2:0] m_col, m_led;

  // Per-window output statistics.
  int cnt_r, cnt_g, cnt_b, cnt_t, cnt_ramp;

  typedef struct {
    logic [2:0] rgb;
    int         wr;
    int         hi_r, hi_g, hi_b, ticks, ramp;
  } vec_t;
  vec_t vt[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int pos;
    bit bnd;
    if (rst) begin
      m_active = 0; m_ramp = 0; m_pt = 0; m_cyc = 0; m_level = 0; m_pend = 0;
      m_col = 3'b000; m_led = 3'b000;
    end else begin
      pos   = m_cyc % PER;  // one PWM step per cycle at PRESCALE=1
      m_led = (m_active && en && pos < m_level) ? m_col : 3'b000;
      bnd   = m_active && (pos == PER - 1);
      m_pt  = bnd && en;
      if (!m_active) begin
        if (en) begin
          m_active = 1; m_ramp = 1; m_cyc = 0; m_level = 0; m_col = {r_in, g_in, b_in};
        end
      end else if (!en) begin
        m_active = 0; m_ramp = 0; m_cyc = 0; m_level = 0;
      end else begin
        if (bnd) begin
          m_col = {r_in, g_in, b_in};
          if (!m_ramp) m_level = m_pend;
          else if (m_level + 1 >= m_pend) begin
            m_level = m_pend;
            m_ramp  = 0;
          end else m_level = m_level + 1;
        end
        m_cyc = m_cyc + 1;
      end
      if (duty_we) m_pend = int'(duty);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model", {24'd0, 3'b000, led_r, led_g, led_b, period_tick, ramping},
          {24'd0, 3'b000, m_led, m_pt, m_ramp});
    cnt_r    += int'(led_r);
    cnt_g    += int'(led_g);
    cnt_b    += int'(led_b);
    cnt_t    += int'(period_tick);
    cnt_ramp += int'(ramping);
  endtask

  task automatic clear_counts();
    cnt_r = 0; cnt_g = 0; cnt_b = 0; cnt_t = 0; cnt_ramp = 0;
  endtask

  task automatic apply_vec(input int idx);
    {r_in, g_in, b_in} = vt[idx].rgb;
    clear_counts();
    for (int c = 0; c < PER; c++) begin
      if (c == 2 && vt[idx].wr >= 0) begin
        duty    = CW'(vt[idx].wr);
        duty_we = 1'b1;
      end
      step();
      duty_we = 1'b0;
    end
    check($sformatf("vec%0d_hi_r", idx), cnt_r, vt[idx].hi_r);
    check($sformatf("vec%0d_hi_g", idx), cnt_g, vt[idx].hi_g);
    check($sformatf("vec%0d_hi_b", idx), cnt_b, vt[idx].hi_b);
    check($sformatf("vec%0d_ticks", idx), cnt_t, vt[idx].ticks);
    check($sformatf("vec%0d_ramp", idx), cnt_ramp, vt[idx].ramp);
  endtask

  initial begin
    // One record per PWM period: colour inputs, optional duty write, expected
    // high-cycle counts per LED, period_tick pulses and cycles spent ramping.
    vt = '{
      '{3'b100, -1, 0, 0, 0, 0, 16}, '{3'b100, -1, 1, 0, 0, 1, 16},
      '{3'b100, -1, 2, 0, 0, 1, 16}, '{3'b100, -1, 3, 0, 0, 1, 16},
      '{3'b100, -1, 4, 0, 0, 1, 16}, '{3'b100, -1, 5, 0, 0, 1, 16},
      '{3'b100, -1, 6, 0, 0, 1, 16}, '{3'b100, -1, 7, 0, 0, 1, 16},
      '{3'b100, -1, 8, 0, 0, 1, 0},  '{3'b100, -1, 8, 0, 0, 1, 0},
      '{3'b100, -1, 8, 0, 0, 1, 0},
      '{3'b010,  0, 0, 8, 0, 1, 0},  '{3'b010, -1, 0, 0, 0, 1, 0},
      '{3'b010, 15, 0, 0, 0, 1, 0},  '{3'b010, -1, 0, 15, 0, 1, 0},
      '{3'b011, -1, 0, 15, 15, 1, 0},
      '{3'b011, -1, 0, 0, 0, 0, 16}, '{3'b011, -1, 0, 1, 1, 1, 16},
      '{3'b011, -1, 0, 2, 2, 1, 16}, '{3'b011, -1, 0, 3, 3, 1, 16}
    };

    rst = 1'b1; en = 1'b1; duty = CW'(5); duty_we = 1'b1;
    r_in = 1'b0; g_in = 1'b0; b_in = 1'b0;
    clear_counts();

    // Reset with enable and a duty write pending: everything stays at zero.
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_outputs", {led_r, led_g, led_b, period_tick, ramping}, 0);
    end

    // The duty write during reset must be lost: ramp to 0 gives two dark periods.
    rst = 1'b0; duty_we = 1'b0; r_in = 1'b1;
    clear_counts();
    for (int c = 0; c < PER; c++) step();
    check("pend0_p0_r", cnt_r, 0);
    check("pend0_p0_ramp", cnt_ramp, 16);
    clear_counts();
    for (int c = 0; c < PER; c++) step();
    check("pend0_p1_r", cnt_r, 0);
    check("pend0_p1_ramp", cnt_ramp, 0);
    check("pend0_p1_tick", cnt_t, 1);

    // Back to IDLE, load duty 8, then ramp and settle in RUN.
    en = 1'b0;
    step();
    check("idle_ramping", ramping, 0);
    duty = CW'(8); duty_we = 1'b1;
    step();
    duty_we = 1'b0;
    step();
    en = 1'b1;
    for (int i = 0; i <= 10; i++) apply_vec(i);

    // Colour change at cycle 5 of a RUN period is held off until the boundary.
    clear_counts();
    for (int c = 0; c < PER; c++) begin
      if (c == 5) begin r_in = 1'b0; g_in = 1'b1; end
      step();
    end
    check("colchg_cur_r", cnt_r, 8);
    check("colchg_cur_g", cnt_g, 0);
    clear_counts();
    for (int c = 0; c < PER; c++) step();
    check("colchg_next_r", cnt_r, 0);
    check("colchg_next_g", cnt_g, 8);

    // Duty extremes 0 and 15, then blue added.
    for (int i = 11; i <= 15; i++) apply_vec(i);

    // Disable at cycle 3 of a RUN period.
    {r_in, g_in, b_in} = 3'b011;
    for (int c = 0; c < 3; c++) step();
    check("pre_disable_g", led_g, 1);
    en = 1'b0;
    step();
    check("disable_leds", {led_r, led_g, led_b}, 0);
    check("disable_ramping", ramping, 0);
    clear_counts();
    for (int c = 0; c < 4; c++) step();
    check("idle_leds", cnt_r + cnt_g + cnt_b + cnt_ramp, 0);

    // Re-enable: ramp restarts from a dark period 0 (duty_pend kept at 15).
    en = 1'b1;
    for (int i = 16; i <= 19; i++) apply_vec(i);

    // Reset in the middle of ramp period 4 with enable held high.
    clear_counts();
    for (int c = 0; c < 6; c++) step();
    check("ramp_p4_part_g", cnt_g, 4);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      check("midramp_rst_out", {led_r, led_g, led_b, period_tick, ramping}, 0);
    end
    rst = 1'b0;
    clear_counts();
    step();
    check("rst_release_ramping", ramping, 1);
    for (int c = 1; c < PER; c++) step();
    check("rst_p0_g", cnt_g, 0);
    check("rst_p0_ramp", cnt_ramp, 16);
    clear_counts();
    for (int c = 0; c < PER; c++) step();
    check("rst_p1_g", cnt_g + cnt_b, 0);
    check("rst_p1_ramp", cnt_ramp, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 1499) == 0);
      en      = ($urandom_range(0, 399) != 0);
      duty_we = ($urandom_range(0, 39) == 0);
      duty    = CW'($urandom);
      if ($urandom_range(0, 7) == 0) {r_in, g_in, b_in} = 3'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
